// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: it drives reg_alu, writes back results and flags, and owns the PC.
// Optional feature macro: SEQ_FLAG_JUMP_EN (conditional JZ/JC); when undefined, ops 0xD/0xE are 2-cycle NOPs.
module cpu_seq_ctrl #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] pc_addr,
  input  logic [11:0]     instr,
  output logic [3:0]      alu_sel,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  input  logic [3:0]      alu_f,
  input  logic            alu_cout,
  output logic            zf,
  output logic            cf,
  output logic            halted,
  input  logic [1:0]      dbg_sel,
  output logic [3:0]      dbg_data
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_tgt;
  logic [3:0]      regs [4];
  logic [1:0]      rd_q;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] imm;
  logic       is_alu_op;
  logic       jump_take;

  assign op        = instr[11:8];
  assign rd        = instr[7:6];
  assign rs        = instr[5:4];
  assign imm       = instr[3:0];
  assign is_alu_op = (op < OP_LDI);
  assign pc_inc    = pc + PC_W'(1);
  assign jump_tgt  = PC_W'(imm);

`ifdef SEQ_FLAG_JUMP_EN
  assign jump_take = ((op == OP_JZ) && zf) || ((op == OP_JC) && cf);
`else
  assign jump_take = 1'b0;
`endif

  assign pc_addr  = pc;
  assign halted   = (state == S_HALT);
  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_alu_op)            state_nxt = S_EXEC;
        else if (op == OP_HALT)   state_nxt = S_HALT;
        else                      state_nxt = S_FETCH;
      end
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // DECODE latches operands for reg_alu; WB commits its result one stage later
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc      <= '0;
      zf      <= 1'b0;
      cf      <= 1'b0;
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          if (is_alu_op) begin
            alu_sel <= op;
            alu_a   <= regs[rd];
            alu_b   <= regs[rs];
            rd_q    <= rd;
          end else if (op == OP_LDI) begin
            regs[rd] <= imm;
            pc       <= pc_inc;
          end else if ((op == OP_JZ) || (op == OP_JC)) begin
            pc <= jump_take ? jump_tgt : pc_inc;
          end
        end
        S_WB: begin
          regs[rd_q] <= alu_f;
          zf         <= (alu_f == 4'h0);
          cf         <= alu_cout;
          pc         <= pc_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl with a synchronous program ROM and a registered reg_alu model around the DUT.
module tb_cpu_seq_ctrl;

  // Stand-in ALU codes for the bench's reg_alu model; the sequencer forwards op unchanged.
  localparam logic [3:0] ALU_ADD_AB   = 4'h0;
  localparam logic [3:0] ALU_XOR_MASK = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  pc_addr;
  logic [11:0] instr;
  logic [3:0]  alu_sel, alu_a, alu_b, alu_f;
  logic        alu_cout, zf, cf, halted;
  logic [1:0]  dbg_sel;
  logic [3:0]  dbg_data;
  logic [11:0] rom [16];

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.PC_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .pc_addr(pc_addr), .instr(instr),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_cout(alu_cout), .zf(zf), .cf(cf), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  function automatic logic [4:0] alu_model(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
    case (sel)
      ALU_ADD_AB:   return {1'b0, a} + {1'b0, b};
      ALU_XOR_MASK: return {1'b0, a ^ b};
      default:      return {1'b0, a & b};
    endcase
  endfunction

  always_ff @(posedge clk) instr <= rom[pc_addr];

  always_ff @(posedge clk) begin
    if (!reset_n) {alu_cout, alu_f} <= 5'd0;
    else          {alu_cout, alu_f} <= alu_model(alu_sel, alu_a, alu_b);
  end

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [11:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [3:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    expq.push_back(e);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    exp_t e;
    n_tests++;
    if (expq.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
    end else begin
      e = expq.pop_front();
      assert (obs === e.val && tag == e.tag)
        else begin
          n_fail++;
          $error("FAIL %s observed=%0h expected=%0h (queued tag %s)", tag, obs, e.val, e.tag);
        end
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx);
    dbg_sel = idx;
    #1;
    check(tag, {4'h0, dbg_data});
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = mk(OP_HALT, 2'd0, 2'd0, 4'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    dbg_sel = 2'd0;
    for (int i = 0; i < 16; i++) rom[i] = 12'($urandom);

    // reset values with arbitrary instruction words
    push("rst_pc", 8'h0); push("rst_sel", 8'h0); push("rst_a", 8'h0); push("rst_b", 8'h0);
    push("rst_zf", 8'h0); push("rst_cf", 8'h0); push("rst_halt", 8'h0);
    push("rst_r0", 8'h0); push("rst_r1", 8'h0); push("rst_r2", 8'h0); push("rst_r3", 8'h0);
    run(3);
    check("rst_pc", {4'h0, pc_addr}); check("rst_sel", {4'h0, alu_sel});
    check("rst_a", {4'h0, alu_a}); check("rst_b", {4'h0, alu_b});
    check("rst_zf", {7'h0, zf}); check("rst_cf", {7'h0, cf}); check("rst_halt", {7'h0, halted});
    check_reg("rst_r0", 2'd0); check_reg("rst_r1", 2'd1);
    check_reg("rst_r2", 2'd2); check_reg("rst_r3", 2'd3);

    // load then add
    clear_rom();
    rom[0] = mk(OP_LDI, 2'd0, 2'd0, 4'h5);
    rom[1] = mk(OP_LDI, 2'd1, 2'd0, 4'h3);
    rom[2] = mk(ALU_ADD_AB, 2'd0, 2'd1, 4'h0);
    reset_n = 1'b1;
    push("ld_r0", 8'h5); push("ld_r1", 8'h3); push("ld_pc", 8'h2);
    run(4);
    check_reg("ld_r0", 2'd0); check_reg("ld_r1", 2'd1); check("ld_pc", {4'h0, pc_addr});
    push("ex_sel", {4'h0, ALU_ADD_AB}); push("ex_a", 8'h5); push("ex_b", 8'h3);
    run(2);
    check("ex_sel", {4'h0, alu_sel}); check("ex_a", {4'h0, alu_a}); check("ex_b", {4'h0, alu_b});
    push("wb_early_r0", 8'h5);
    run(1);
    check_reg("wb_early_r0", 2'd0);
    push("add_r0", 8'h8); push("add_zf", 8'h0); push("add_cf", 8'h0); push("add_pc", 8'h3);
    run(1);
    check_reg("add_r0", 2'd0); check("add_zf", {7'h0, zf}); check("add_cf", {7'h0, cf});
    check("add_pc", {4'h0, pc_addr});
    push("halt_early", 8'h0);
    run(1);
    check("halt_early", {7'h0, halted});
    push("halt_set", 8'h1);
    run(1);
    check("halt_set", {7'h0, halted});

    // overflow then JC
    clear_rom();
    rom[0] = mk(OP_LDI, 2'd0, 2'd0, 4'hA);
    rom[1] = mk(OP_LDI, 2'd1, 2'd0, 4'h7);
    rom[2] = mk(ALU_ADD_AB, 2'd0, 2'd1, 4'h0);
    rom[3] = mk(OP_JC, 2'd0, 2'd0, 4'h9);
    restart();
    push("ovf_r0", 8'h1); push("ovf_cf", 8'h1); push("ovf_zf", 8'h0);
    run(8);
    check_reg("ovf_r0", 2'd0); check("ovf_cf", {7'h0, cf}); check("ovf_zf", {7'h0, zf});
`ifdef SEQ_FLAG_JUMP_EN
    push("jc_pc", 8'h9);
`else
    push("jc_pc", 8'h4);
`endif
    run(2);
    check("jc_pc", {4'h0, pc_addr});

    // zero flag then JZ taken
    clear_rom();
    rom[0] = mk(OP_LDI, 2'd2, 2'd0, 4'h6);
    rom[1] = mk(ALU_XOR_MASK, 2'd2, 2'd2, 4'h0);
    rom[2] = mk(OP_JZ, 2'd0, 2'd0, 4'h0);
    restart();
    push("xor_r2", 8'h0); push("xor_zf", 8'h1);
    run(6);
    check_reg("xor_r2", 2'd2); check("xor_zf", {7'h0, zf});
`ifdef SEQ_FLAG_JUMP_EN
    push("jz_pc", 8'h0);
`else
    push("jz_pc", 8'h3);
`endif
    run(2);
    check("jz_pc", {4'h0, pc_addr});

    // zf cleared by a later ALU op, JZ falls through
    clear_rom();
    rom[0] = mk(OP_LDI, 2'd2, 2'd0, 4'h6);
    rom[1] = mk(ALU_XOR_MASK, 2'd2, 2'd2, 4'h0);
    rom[2] = mk(OP_LDI, 2'd0, 2'd0, 4'h1);
    rom[3] = mk(ALU_ADD_AB, 2'd0, 2'd0, 4'h0);
    rom[4] = mk(OP_JZ, 2'd0, 2'd0, 4'h9);
    restart();
    push("nz_zf1", 8'h1);
    run(6);
    check("nz_zf1", {7'h0, zf});
    push("nz_r0", 8'h2); push("nz_zf0", 8'h0);
    run(6);
    check_reg("nz_r0", 2'd0); check("nz_zf0", {7'h0, zf});
    push("nz_pc", 8'h5);
    run(2);
    check("nz_pc", {4'h0, pc_addr});

    // 15 LDIs then HALT at 0xF
    for (int i = 0; i < 15; i++) rom[i] = mk(OP_LDI, 2'(i % 4), 2'd0, 4'(i));
    rom[15] = mk(OP_HALT, 2'd0, 2'd0, 4'h0);
    restart();
    push("hw_pc15", 8'hF);
    run(30);
    check("hw_pc15", {4'h0, pc_addr});
    run(2);
    for (int c = 0; c < 10; c++) begin
      push("hold_halt", 8'h1); push("hold_pc", 8'hF);
      run(1);
      check("hold_halt", {7'h0, halted}); check("hold_pc", {4'h0, pc_addr});
    end
    push("hw_r2", 8'hE); push("hw_r3", 8'hB);
    check_reg("hw_r2", 2'd2); check_reg("hw_r3", 2'd3);

    // replace HALT with LDI: pc wraps to 0
    rom[15] = mk(OP_LDI, 2'd3, 2'd0, 4'hF);
    restart();
    push("wrap_pc", 8'h0); push("wrap_r3", 8'hF); push("wrap_halt", 8'h0);
    run(32);
    check("wrap_pc", {4'h0, pc_addr}); check_reg("wrap_r3", 2'd3);
    check("wrap_halt", {7'h0, halted});

    // reset asserted during EXEC of ADD
    clear_rom();
    rom[0] = mk(OP_LDI, 2'd0, 2'd0, 4'h5);
    rom[1] = mk(OP_LDI, 2'd1, 2'd0, 4'h3);
    rom[2] = mk(ALU_ADD_AB, 2'd0, 2'd1, 4'h0);
    restart();
    push("mid_exec_a", 8'h5);
    run(6);
    check("mid_exec_a", {4'h0, alu_a});
    reset_n = 1'b0;
    push("mid_r0", 8'h0); push("mid_r1", 8'h0); push("mid_cf", 8'h0);
    push("mid_pc", 8'h0); push("mid_a", 8'h0);
    run(1);
    check_reg("mid_r0", 2'd0); check_reg("mid_r1", 2'd1); check("mid_cf", {7'h0, cf});
    check("mid_pc", {4'h0, pc_addr}); check("mid_a", {4'h0, alu_a});
    push("mid_hold_r0", 8'h0);
    run(1);
    check_reg("mid_hold_r0", 2'd0);
    reset_n = 1'b1;
    push("mid_restart_r0", 8'h5); push("mid_restart_pc", 8'h1);
    run(2);
    check_reg("mid_restart_r0", 2'd0); check("mid_restart_pc", {4'h0, pc_addr});

    if (expq.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
